// File: rtl/ssp_tx.sv
// ---------------------------------------------------------------------------
// ssp_tx -- synchronous serial port transmitter (frame-sync format)
//
// Pops 8-bit words from an external FIFO and sends them MSB first on ssptxd.
// The serial clock is pclk/2. A frame starts with one sspclkout period of
// sspfssout. When another word is already queued, that word's frame sync
// overlaps bit 0 of the current word, so the words go out back to back.
//
// Ports
//   pclk       in   system clock, rising edge
//   clear      in   asynchronous active-low reset
//   tx_nempty  in   FIFO non-empty flag
//   tx_word    in   FIFO read data, valid the cycle after tx_rd
//   tx_rd      out  one-cycle FIFO pop request
//   sspclkout  out  serial clock (pclk/2), free-running out of reset
//   sspfssout  out  frame sync, one sspclkout period wide
//   ssptxd     out  serial data, MSB first
//   sspoe_b    out  active-low output enable for ssptxd
//   busy       out  high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module ssp_tx (
    input  logic       pclk,
    input  logic       clear,
    input  logic       tx_nempty,
    input  logic [7:0] tx_word,
    output logic       tx_rd,
    output logic       sspclkout,
    output logic       sspfssout,
    output logic       ssptxd,
    output logic       sspoe_b,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LOAD  = 3'd2,
        SYNC  = 3'd3,
        SHIFT = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  shift_reg, shift_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic        fss_reg, fss_next;
    logic        rd_reg, rd_next;
    logic        sclk_reg;
    logic        rise;

    // sspclkout is low before the edge that makes it go high, so a low
    // sspclkout marks the coming pclk edge as a rise edge.
    assign rise = ~sclk_reg;

    always_ff @(posedge pclk or negedge clear) begin
        if (!clear) begin
            sclk_reg <= 1'b0;
        end else begin
            sclk_reg <= ~sclk_reg;
        end
    end

    always_ff @(posedge pclk or negedge clear) begin
        if (!clear) begin
            state_reg <= IDLE;
            shift_reg <= 8'd0;
            cnt_reg   <= 3'd0;
            fss_reg   <= 1'b0;
            rd_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            fss_reg   <= fss_next;
            rd_reg    <= rd_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        fss_next   = fss_reg;
        rd_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (tx_nempty) begin
                    state_next = READ;
                    rd_next    = 1'b1;
                end
            end

            READ: begin
                state_next = LOAD;
                cnt_next   = 3'd0;
            end

            LOAD: begin
                // LOAD can span one or two pclk cycles depending on the
                // sspclkout phase. The counter is idle here, so it doubles
                // as a "word already captured" marker: capture on the first
                // LOAD edge only, while the FIFO data is known to be valid.
                if (cnt_reg == 3'd0) begin
                    shift_next = tx_word;
                    cnt_next   = 3'd1;
                end
                if (rise) begin
                    state_next = SYNC;
                    fss_next   = 1'b1;
                    cnt_next   = 3'd0;
                end
            end

            SYNC: begin
                if (rise) begin
                    state_next = SHIFT;
                    fss_next   = 1'b0;
                    cnt_next   = 3'd7;
                end
            end

            SHIFT: begin
                if (rise) begin
                    if (cnt_reg != 3'd0) begin
                        shift_next = {shift_reg[6:0], 1'b0};
                        cnt_next   = cnt_reg - 3'd1;
                        // Edge that starts bit 0: decide whether to chain
                        // the next word. A raised frame sync also serves as
                        // the "reload pending" flag for the next rise edge.
                        if (cnt_reg == 3'd1 && tx_nempty) begin
                            rd_next  = 1'b1;
                            fss_next = 1'b1;
                        end
                    end else if (fss_reg) begin
                        shift_next = tx_word;
                        cnt_next   = 3'd7;
                        fss_next   = 1'b0;
                    end else begin
                        state_next = IDLE;
                        shift_next = 8'd0;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Data and enable are derived from registered state that only changes
    // on rise edges while shifting, so they are stable across sspclkout falls.
    assign tx_rd     = rd_reg;
    assign sspclkout = sclk_reg;
    assign sspfssout = fss_reg;
    assign ssptxd    = (state_reg == SHIFT) & shift_reg[7];
    assign sspoe_b   = (state_reg != SHIFT);
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_ssp_tx.sv
// ---------------------------------------------------------------------------
// tb_ssp_tx -- directed self-checking bench for ssp_tx.
// A small FIFO model feeds the DUT; a monitor decodes the serial stream at
// each sspclkout-high half period and checks the handshake rules on the fly.
// ---------------------------------------------------------------------------
module tb_ssp_tx;

    logic       pclk = 1'b0;
    logic       clear;
    logic       tx_nempty;
    logic [7:0] tx_word;
    logic       tx_rd, sspclkout, sspfssout, ssptxd, sspoe_b, busy;

    int total = 0;
    int bad   = 0;

    ssp_tx dut (
        .pclk      (pclk),
        .clear     (clear),
        .tx_nempty (tx_nempty),
        .tx_word   (tx_word),
        .tx_rd     (tx_rd),
        .sspclkout (sspclkout),
        .sspfssout (sspfssout),
        .ssptxd    (ssptxd),
        .sspoe_b   (sspoe_b),
        .busy      (busy)
    );

    always #5 pclk = ~pclk;

    // FIFO model: registered read data, valid the cycle after tx_rd.
    logic [7:0] mem [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    bit         force_empty = 1'b0;

    assign tx_nempty = (wr_ptr != rd_ptr) && !force_empty;

    always @(posedge pclk) begin
        if (tx_rd === 1'b1) begin
            tx_word <= mem[rd_ptr[3:0]];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [7:0] w);
        mem[wr_ptr[3:0]] = w;
        wr_ptr = wr_ptr + 1;
        $display("push word 0x%02h", w);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor state
    logic [63:0] bits  = '0;
    logic [63:0] fmask = '0;
    int nbits = 0, rd_cnt = 0, sync_cnt = 0, oe_runs = 0, frame_cyc = 0;
    bit prev_rd = 0, prev_oe = 1, prev_valid = 0, prev_txd = 0;

    always @(negedge pclk) begin
        if (clear === 1'b1) begin
            if (tx_rd) rd_cnt++;
            chk("rd_while_empty", {31'd0, tx_rd & ~tx_nempty}, 32'd0);
            chk("rd_consecutive", {31'd0, tx_rd & prev_rd}, 32'd0);
            prev_rd = tx_rd;
            if (sspfssout || !sspoe_b) frame_cyc++;
            if (prev_oe && !sspoe_b) oe_runs++;
            prev_oe = sspoe_b;
            if (sspclkout) begin
                if (!sspoe_b) begin
                    bits  = {bits[62:0], ssptxd};
                    fmask = {fmask[62:0], sspfssout};
                    nbits++;
                end else if (sspfssout) begin
                    sync_cnt++;
                end
                prev_txd   = ssptxd;
                prev_valid = 1'b1;
            end else begin
                if (prev_valid) chk("txd_stable", {31'd0, ssptxd}, {31'd0, prev_txd});
                prev_valid = 1'b0;
            end
        end else begin
            prev_valid = 1'b0;
            prev_rd    = 1'b0;
            prev_oe    = 1'b1;
        end
    end

    int nb0, rd0, sy0, oe0, fc0;

    task automatic snap();
        nb0 = nbits; rd0 = rd_cnt; sy0 = sync_cnt; oe0 = oe_runs; fc0 = frame_cyc;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin @(negedge pclk); n++; end
        chk("start_timeout", {31'd0, n < 20}, 32'd1);
        n = 0;
        while (busy !== 1'b0 && n < 400) begin @(negedge pclk); n++; end
        chk("done_timeout", {31'd0, n < 400}, 32'd1);
        @(negedge pclk);
    endtask

    task automatic wait_bits(input int target);
        int n;
        n = 0;
        while ((nbits - nb0) < target && n < 200) begin @(negedge pclk); n++; end
        chk("bits_timeout", {31'd0, n < 200}, 32'd1);
    endtask

    task automatic chk_reset_outs();
        chk("rst_sclk", {31'd0, sspclkout}, 32'd0);
        chk("rst_fss",  {31'd0, sspfssout}, 32'd0);
        chk("rst_txd",  {31'd0, ssptxd},    32'd0);
        chk("rst_oe_b", {31'd0, sspoe_b},   32'd1);
        chk("rst_rd",   {31'd0, tx_rd},     32'd0);
        chk("rst_busy", {31'd0, busy},      32'd0);
    endtask

    initial begin
        int lat, e_tog, e_rd, e_fss, e_busy, e_oe;
        logic prev_sclk;

        // ---- reset state ----
        clear = 1'b0;
        repeat (3) @(negedge pclk);
        chk_reset_outs();
        $display("reset state checked");

        // ---- idle, 40 cycles ----
        clear = 1'b1;
        prev_sclk = 1'b0;
        e_tog = 0; e_rd = 0; e_fss = 0; e_busy = 0; e_oe = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (sspclkout === prev_sclk) e_tog++;
            prev_sclk = sspclkout;
            if (tx_rd !== 1'b0) e_rd++;
            if (sspfssout !== 1'b0) e_fss++;
            if (busy !== 1'b0) e_busy++;
            if (sspoe_b !== 1'b1) e_oe++;
        end
        chk("idle_toggle", e_tog, 0);
        chk("idle_rd", e_rd, 0);
        chk("idle_fss", e_fss, 0);
        chk("idle_busy", e_busy, 0);
        chk("idle_oe_b", e_oe, 0);
        $display("idle 40 cycles: toggle_err=%0d", e_tog);

        // ---- single word 0xA5 ----
        snap();
        push(8'hA5);
        lat = 0;
        while (sspfssout !== 1'b1 && lat < 10) begin @(negedge pclk); lat++; end
        chk("latency_le4", {31'd0, lat <= 4}, 32'd1);
        wait_idle();
        chk("a5_nbits", nbits - nb0, 8);
        chk("a5_data", {24'd0, bits[7:0]}, 32'hA5);
        chk("a5_fss_in_data", {24'd0, fmask[7:0]}, 32'd0);
        chk("a5_rd_pulses", rd_cnt - rd0, 1);
        chk("a5_sync", sync_cnt - sy0, 1);
        chk("a5_oe_runs", oe_runs - oe0, 1);
        chk("a5_frame_len", frame_cyc - fc0, 18);
        chk("a5_oe_b_end", {31'd0, sspoe_b}, 32'd1);
        $display("word 0xA5: latency=%0d data=0x%02h frame=%0d", lat, bits[7:0], frame_cyc - fc0);

        // ---- back-to-back 0x63, 0x61 ----
        snap();
        push(8'h63);
        push(8'h61);
        wait_idle();
        chk("b2b_nbits", nbits - nb0, 16);
        chk("b2b_data", {16'd0, bits[15:0]}, 32'h6361);
        chk("b2b_fss_bit0", {16'd0, fmask[15:0]}, 32'h0100);
        chk("b2b_rd_pulses", rd_cnt - rd0, 2);
        chk("b2b_sync", sync_cnt - sy0, 1);
        chk("b2b_oe_runs", oe_runs - oe0, 1);
        chk("b2b_frame_len", frame_cyc - fc0, 34);
        $display("back-to-back: data=0x%04h fss_mask=0x%04h", bits[15:0], fmask[15:0]);

        // ---- empty at decision edge: 0x74, flag drops during bit 3 ----
        snap();
        push(8'h74);
        push(8'h5A);
        wait_bits(5);
        force_empty = 1'b1;
        wait_idle();
        chk("emp_nbits", nbits - nb0, 8);
        chk("emp_data", {24'd0, bits[7:0]}, 32'h74);
        chk("emp_fss_in_data", {24'd0, fmask[7:0]}, 32'd0);
        chk("emp_rd_pulses", rd_cnt - rd0, 1);
        chk("emp_busy", {31'd0, busy}, 32'd0);
        $display("empty at decision: data=0x%02h", bits[7:0]);

        snap();
        force_empty = 1'b0;
        wait_idle();
        chk("resume_data", {24'd0, bits[7:0]}, 32'h5A);
        chk("resume_sync", sync_cnt - sy0, 1);
        chk("resume_rd", rd_cnt - rd0, 1);
        $display("resumed word: data=0x%02h", bits[7:0]);

        // ---- reset during bit 4 of 0x73 ----
        snap();
        push(8'h73);
        wait_bits(4);
        #1 clear = 1'b0;
        #1 chk_reset_outs();
        repeat (3) @(negedge pclk);
        push(8'h3C);
        snap();
        clear = 1'b1;
        wait_idle();
        chk("rst_sync", sync_cnt - sy0, 1);
        chk("rst_nbits", nbits - nb0, 8);
        chk("rst_data", {24'd0, bits[7:0]}, 32'h3C);
        chk("rst_rd", rd_cnt - rd0, 1);
        $display("after mid-frame reset: data=0x%02h sync=%0d", bits[7:0], sync_cnt - sy0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssp_tx.md
SSP_TX -- requirements
Module: ssp_tx

Interface
REQ-001 pclk  input  1  system clock; all state advances on its rising edge.
REQ-002 clear  input  1  asynchronous, active-low reset; forces every register to its reset value immediately, independent of pclk.
REQ-003 tx_nempty  input  1  transmit FIFO non-empty flag (high = at least one word queued).
REQ-004 tx_word  input  8  transmit FIFO read data; valid in the pclk cycle after the cycle in which tx_rd is high.
REQ-005 tx_rd  output  1  FIFO read request; one pclk cycle wide; the FIFO pops one word per high cycle.
REQ-006 sspclkout  output  1  serial clock, pclk/2, free-running whenever clear is high.
REQ-007 sspfssout  output  1  frame sync; high for one sspclkout period.
REQ-008 ssptxd  output  1  serial data, MSB first.
REQ-009 sspoe_b  output  1  active-low output enable for ssptxd; low only while a data bit is driven.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 sspclkout SHALL toggle on every pclk edge; a "rise edge" is the pclk edge on which sspclkout goes 0->1.
REQ-012 ssptxd and sspfssout SHALL change only on rise edges, so the receiver samples them on the sspclkout falling edge.
REQ-013 The FSM SHALL have states IDLE, READ, LOAD, SYNC and SHIFT.
REQ-014 IDLE: tx_rd=0, sspfssout=0, sspoe_b=1; on an edge with tx_nempty=1, go to READ.
REQ-015 READ: tx_rd=1 for exactly one pclk cycle; next state is LOAD.
REQ-016 LOAD: capture tx_word into the 8-bit shift register; hold until the next rise edge, then enter SYNC with sspfssout=1.
REQ-017 SYNC: last one sspclkout period (2 pclk); at the following rise edge, sspfssout=0, sspoe_b=0, ssptxd=shift[7], and the FSM enters SHIFT with bit counter=7.
REQ-018 SHIFT: at each rise edge, shift left by one and decrement the counter; ssptxd always equals the current MSB; each bit lasts exactly 2 pclk.
REQ-019 During the bit-0 period, if tx_nempty=1 at the rise edge that starts bit 0, the FSM SHALL:
  - issue a tx_rd pulse;
  - load the next word;
  - drive sspfssout=1 concurrently with bit 0;
  - start the new word's MSB at the next rise edge with no gap (continuous framing, no SYNC state).
REQ-020 If tx_nempty=0 at that edge: at the rise edge ending bit 0, sspoe_b=1, ssptxd=0, and the FSM returns to IDLE.
REQ-021 tx_rd SHALL never be asserted while tx_nempty=0, and never for more than one consecutive cycle.
REQ-022 Latency from tx_nempty rising in IDLE to sspfssout=1 SHALL be at most 4 pclk cycles; one frame (SYNC plus 8 bits) is 18 pclk cycles.
REQ-023 Changes on tx_nempty outside IDLE and the bit-0 decision edge SHALL be ignored.

Reset
REQ-024 While clear=0: state=IDLE, sspclkout=0, sspfssout=0, ssptxd=0, sspoe_b=1, tx_rd=0, busy=0, shift register=0, counter=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; the partially sent word is not retransmitted.
REQ-026 After clear deasserts, the first rise edge is the first pclk edge.

Verification
REQ-027 Idle: clear released, tx_nempty=0 for 40 cycles -> sspclkout toggles every pclk; tx_rd, sspfssout and busy stay 0; sspoe_b stays 1.
REQ-028 Single word: 0xA5 queued -> one tx_rd pulse, then 2 pclk of sspfssout=1, then ssptxd = 1,0,1,0,0,1,0,1 (2 pclk per bit) with sspoe_b=0, then sspoe_b=1 and busy=0.
REQ-029 Back-to-back: 0x63 and 0x61 queued -> sspfssout high during bit 0 of 0x63; the MSB of 0x61 follows immediately; exactly 2 tx_rd pulses; 16 contiguous bit periods.
REQ-030 Empty at decision edge: tx_nempty falls during bit 3 of 0x74 -> no sspfssout during bit 0; return to IDLE after bit 0.
REQ-031 Reset mid-shift: clear=0 during bit 4 of 0x73 -> all outputs take reset values asynchronously; after release with tx_nempty=1, a fresh frame starts with SYNC.
REQ-032 Protocol checker: tx_rd only when tx_nempty=1, never 2 consecutive cycles; ssptxd is stable across each sspclkout falling edge.
